// File: rtl/pwm_pkg.sv
// Shared types for the dead-time gate driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int DT_BITS_DEFAULT = 4;

    // Binary-encoded gate driver states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DT_RISE = 3'd1,
        HI_ON   = 3'd2,
        DT_FALL = 3'd3,
        LO_ON   = 3'd4,
        FAULT   = 3'd5
    } dt_state_t;

endpackage

// File: rtl/pwm_dead_time_if.sv
// Bundle between the PWM source and the complementary gate driver.
// Latency: n/a (wires only).
// Backpressure: none; all signals are plain levels sampled every cycle.
// master: drives pwm_in, dead_time, enable, fault, clear_fault; reads gate outputs.
// slave : the gate driver itself.
interface pwm_dead_time_if
    import pwm_pkg::*;
#(
    parameter int DT_BITS = DT_BITS_DEFAULT
) ();

    logic               pwm_in;
    logic [DT_BITS-1:0] dead_time;
    logic               enable;
    logic               fault;
    logic               clear_fault;
    logic               pwm_hi;
    logic               pwm_lo;
    logic               fault_active;

    modport master (
        output pwm_in, dead_time, enable, fault, clear_fault,
        input  pwm_hi, pwm_lo, fault_active
    );

    modport slave (
        input  pwm_in, dead_time, enable, fault, clear_fault,
        output pwm_hi, pwm_lo, fault_active
    );

endinterface

// File: rtl/pwm_dead_time_counter.sv
// Dead-time down counter: loads a gap length, decrements to zero and holds there.
// Latency: load/dec take effect at the next rising edge; zero is combinational on the count.
// Backpressure: none.
// Ports: clk, rst_n (sync, active-low), load, load_val, dec -> zero.
module dt_counter #(
    parameter int DT_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DT_BITS-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DT_BITS-1:0] cnt;

    // Load wins over decrement; the count saturates at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - DT_BITS'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_dead_time.sv
// Complementary gate driver: inserts a dead_time+1 cycle both-low gap at every edge, with enable and latched fault.
// Latency: outputs are registered and decoded from the next state, so they change at the edge that samples the input.
// Backpressure: none; inputs are levels sampled every cycle.
// Ports: clk, rst_n (sync, active-low), bus (slave): pwm_in, dead_time, enable, fault, clear_fault -> pwm_hi, pwm_lo, fault_active.
module pwm_dead_time
    import pwm_pkg::*;
#(
    parameter int DT_BITS = DT_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_dead_time_if.slave   bus
);

    dt_state_t state, state_nxt;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;

    dt_counter #(.DT_BITS(DT_BITS)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (bus.dead_time),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fault first, then enable (ignored while latched in FAULT), then per-state rules.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (bus.fault) begin
            state_nxt = FAULT;
        end else if (state == FAULT) begin
            if (bus.clear_fault) begin
                state_nxt = IDLE;
            end
        end else if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = bus.pwm_in ? DT_RISE : DT_FALL;
                    cnt_load  = 1'b1;
                end
                DT_RISE: begin
                    // High side never came on, so falling back needs no gap.
                    if (!bus.pwm_in) begin
                        state_nxt = LO_ON;
                    end else if (cnt_zero) begin
                        state_nxt = HI_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                HI_ON: begin
                    if (!bus.pwm_in) begin
                        state_nxt = DT_FALL;
                        cnt_load  = 1'b1;
                    end
                end
                DT_FALL: begin
                    if (bus.pwm_in) begin
                        state_nxt = HI_ON;
                    end else if (cnt_zero) begin
                        state_nxt = LO_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                LO_ON: begin
                    if (bus.pwm_in) begin
                        state_nxt = DT_RISE;
                        cnt_load  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Decoding from state_nxt keeps the outputs registered yet aligned with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.pwm_hi       <= 1'b0;
            bus.pwm_lo       <= 1'b0;
            bus.fault_active <= 1'b0;
        end else begin
            bus.pwm_hi       <= (state_nxt == HI_ON);
            bus.pwm_lo       <= (state_nxt == LO_ON);
            bus.fault_active <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_pwm_dead_time.sv
// Directed bench for pwm_dead_time: reset, gaps, short pulse, fault latch, enable, mid-gap dead_time change.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_dead_time;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    pwm_dead_time_if #(.DT_BITS(4)) dif ();

    pwm_dead_time #(.DT_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    logic [2:0] outs;
    assign outs = {dif.pwm_hi, dif.pwm_lo, dif.fault_active};

    // Gate pair must never overlap, checked every cycle including reset.
    always @(negedge clk) begin
        total++;
        if ((dif.pwm_hi & dif.pwm_lo) === 1'b1) begin
            bad++;
            $display("FAIL overlap t=%0t hi=%b lo=%b want not both 1", $time, dif.pwm_hi, dif.pwm_lo);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.enable = 1'b1; dif.pwm_in = 1'b1; dif.fault = 1'b1;
        dif.clear_fault = 1'b0; dif.dead_time = 4'd0;
        for (int j = 0; j < 2; j++) begin
            cycle();
            total++;
            if (outs !== 3'b000) begin
                bad++; $display("FAIL reset j=%0d got=%b want=000", j, outs);
            end
        end
        dif.fault = 1'b0; dif.enable = 1'b0; rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            dif.pwm_in = j[0];
            cycle();
            total++;
            if (outs !== 3'b000) begin
                bad++; $display("FAIL idle_disabled j=%0d got=%b want=000", j, outs);
            end
        end
    endtask

    // Square wave, 20-cycle period, dead_time=3: each edge gives 4 both-low cycles.
    task automatic test_dead_time();
        logic [2:0] exp;
        logic       lvl;
        dif.dead_time = 4'd3; dif.enable = 1'b1;
        for (int h = 0; h < 5; h++) begin
            lvl = h[0];
            dif.pwm_in = lvl;
            for (int j = 0; j < 10; j++) begin
                cycle();
                exp = (j < 4) ? 3'b000 : (lvl ? 3'b100 : 3'b010);
                total++;
                if (outs !== exp) begin
                    bad++; $display("FAIL dead_time3 h=%0d j=%0d got=%b want=%b", h, j, outs, exp);
                end
            end
        end
    endtask

    // dead_time=0 -> 1-cycle gap; dead_time=15 -> 16-cycle gap.
    task automatic test_zero_max_gap();
        logic [2:0] exp;
        logic       lvl;
        int         dtv;
        for (int s = 0; s < 4; s++) begin
            dtv = (s < 2) ? 0 : 15;
            lvl = ~s[0];
            dif.dead_time = 4'(dtv);
            dif.pwm_in = lvl;
            for (int j = 0; j < dtv + 5; j++) begin
                cycle();
                exp = (j <= dtv) ? 3'b000 : (lvl ? 3'b100 : 3'b010);
                total++;
                if (outs !== exp) begin
                    bad++; $display("FAIL gap_dt%0d s=%0d j=%0d got=%b want=%b", dtv, s, j, outs, exp);
                end
            end
        end
    endtask

    // From LO_ON with dead_time=5, a 3-cycle high pulse never reaches the high side.
    task automatic test_short_pulse();
        logic [2:0] exp;
        dif.dead_time = 4'd5;
        for (int j = 0; j < 8; j++) begin
            dif.pwm_in = (j < 3);
            cycle();
            exp = (j < 3) ? 3'b000 : 3'b010;
            total++;
            if (outs !== exp) begin
                bad++; $display("FAIL short_pulse j=%0d got=%b want=%b", j, outs, exp);
            end
        end
    endtask

    task automatic test_fault();
        logic [2:0] exp;
        dif.dead_time = 4'd2; dif.pwm_in = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cycle();
            exp = (j < 3) ? 3'b000 : 3'b100;
            total++;
            if (outs !== exp) begin
                bad++; $display("FAIL fault_pre j=%0d got=%b want=%b", j, outs, exp);
            end
        end
        dif.fault = 1'b1;
        cycle();
        total++;
        if (outs !== 3'b001) begin
            bad++; $display("FAIL fault_entry got=%b want=001", outs);
        end
        dif.fault = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            total++;
            if (outs !== 3'b001) begin
                bad++; $display("FAIL fault_hold j=%0d got=%b want=001", j, outs);
            end
        end
        dif.fault = 1'b1; dif.clear_fault = 1'b1;
        cycle();
        total++;
        if (outs !== 3'b001) begin
            bad++; $display("FAIL fault_beats_clear got=%b want=001", outs);
        end
        dif.fault = 1'b0; dif.clear_fault = 1'b0;
        cycle();
        total++;
        if (outs !== 3'b001) begin
            bad++; $display("FAIL fault_after_both got=%b want=001", outs);
        end
        dif.clear_fault = 1'b1;
        cycle();
        total++;
        if (outs !== 3'b000) begin
            bad++; $display("FAIL fault_clear got=%b want=000", outs);
        end
        dif.clear_fault = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle();
            exp = (j < 3) ? 3'b000 : 3'b100;
            total++;
            if (outs !== exp) begin
                bad++; $display("FAIL fault_recover j=%0d got=%b want=%b", j, outs, exp);
            end
        end
    endtask

    task automatic test_enable();
        logic [2:0] exp;
        dif.enable = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cycle();
            total++;
            if (outs !== 3'b000) begin
                bad++; $display("FAIL enable_off j=%0d got=%b want=000", j, outs);
            end
        end
        dif.enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cycle();
            exp = (j < 3) ? 3'b000 : 3'b100;
            total++;
            if (outs !== exp) begin
                bad++; $display("FAIL enable_on j=%0d got=%b want=%b", j, outs, exp);
            end
        end
    endtask

    // dead_time 8->2 right after the falling-gap load: this gap stays 9, next is 3.
    task automatic test_mid_change();
        logic [2:0] exp;
        dif.dead_time = 4'd8; dif.pwm_in = 1'b0;
        for (int j = 0; j < 12; j++) begin
            cycle();
            if (j == 0) dif.dead_time = 4'd2;
            exp = (j < 9) ? 3'b000 : 3'b010;
            total++;
            if (outs !== exp) begin
                bad++; $display("FAIL mid_change_gap j=%0d got=%b want=%b", j, outs, exp);
            end
        end
        dif.pwm_in = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cycle();
            exp = (j < 3) ? 3'b000 : 3'b100;
            total++;
            if (outs !== exp) begin
                bad++; $display("FAIL mid_change_next j=%0d got=%b want=%b", j, outs, exp);
            end
        end
    endtask

    // Reset while latched in FAULT clears the fault without clear_fault.
    task automatic test_reset_mid_fault();
        dif.fault = 1'b1;
        cycle();
        total++;
        if (outs !== 3'b001) begin
            bad++; $display("FAIL rst_fault_entry got=%b want=001", outs);
        end
        dif.fault = 1'b0; rst_n = 1'b0;
        cycle();
        total++;
        if (outs !== 3'b000) begin
            bad++; $display("FAIL rst_in_fault got=%b want=000", outs);
        end
        rst_n = 1'b1; dif.dead_time = 4'd0; dif.pwm_in = 1'b1;
        cycle();
        total++;
        if (outs !== 3'b000) begin
            bad++; $display("FAIL rst_release_gap got=%b want=000", outs);
        end
        cycle();
        total++;
        if (outs !== 3'b100) begin
            bad++; $display("FAIL rst_release_on got=%b want=100", outs);
        end
    endtask

    initial begin
        test_reset();
        test_dead_time();
        test_zero_max_gap();
        test_short_pulse();
        test_fault();
        test_enable();
        test_mid_change();
        test_reset_mid_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_dead_time.md
# pwm_dead_time

Downstream stage of the PWM top module. Takes the registered single-ended PWM output and drives a complementary high-side/low-side gate pair. Inserts a programmable dead time at every edge so the two outputs are never high together. Adds an enable gate and a latched fault shutdown.

## Interface
Parameters:
- DT_BITS, 4, width of the dead_time input; gap range 1..2^DT_BITS cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pwm_in  in  1  registered PWM from the PWM top module; synchronous to clk.
- dead_time  in  DT_BITS  dead-time setting; both-low gap = dead_time+1 cycles.
- enable  in  1  1 = drive outputs; 0 = both outputs low.
- fault  in  1  synchronous fault request; level-sensitive.
- clear_fault  in  1  single-cycle request to leave the fault state.
- pwm_hi  out  1  high-side gate drive, registered.
- pwm_lo  out  1  low-side gate drive, registered.
- fault_active  out  1  1 while in the FAULT state, registered.

## Operation
- States: IDLE, DT_RISE, HI_ON, DT_FALL, LO_ON, FAULT.
- Outputs decode from the state:
  - HI_ON: pwm_hi=1, pwm_lo=0.
  - LO_ON: pwm_hi=0, pwm_lo=1.
  - All other states: both outputs 0.
  - FAULT also sets fault_active=1.
- Transition priority is the same in every state, highest first:
  1. fault=1 → FAULT.
  2. enable=0 → IDLE. In FAULT, enable is ignored.
  3. The state-specific rules below.
- IDLE:
  - pwm_in=1 → DT_RISE.
  - pwm_in=0 → DT_FALL.
  - Either move loads cnt=dead_time.
- DT_RISE:
  - pwm_in=0 → LO_ON. The high side never turned on, so no gap is needed.
  - cnt==0 → HI_ON.
  - Otherwise cnt decrements.
- HI_ON: pwm_in=0 → DT_FALL, loading cnt=dead_time.
- DT_FALL:
  - pwm_in=1 → HI_ON.
  - cnt==0 → LO_ON.
  - Otherwise cnt decrements.
- LO_ON: pwm_in=1 → DT_RISE, loading cnt=dead_time.
- FAULT: clear_fault=1 and fault=0 → IDLE. Otherwise stay.
- dead_time is sampled only at counter load. Changing it mid-gap does not affect the gap in progress.
- Invariant: pwm_hi & pwm_lo == 0 on every cycle, including reset and fault entry.
- Arithmetic: cnt is DT_BITS wide, unsigned, decrement only, never wraps (stops at 0).

## Timing
- Reset (rst_n=0 at an edge) gives: state=IDLE, cnt=0, pwm_hi=0, pwm_lo=0, fault_active=0.
- Reset mid-gap or mid-fault returns to IDLE, clearing the fault.
- Gap latency: pwm_in falls and is sampled at edge k while in HI_ON.
  - pwm_hi=0 from edge k.
  - pwm_lo=1 from edge k+dead_time+1.
  - Rising edges are symmetric.
- Minimum gap is 1 cycle (dead_time=0). Maximum gap is 2^DT_BITS cycles.
- A pwm_in pulse of dead_time+1 cycles or fewer is swallowed: the output stays on the opposite side or both stay low.
- Fault sampled at edge k:
  - Both outputs 0 and fault_active=1 from edge k.
  - fault beats a simultaneous clear_fault.
- clear_fault with fault=0 at edge k gives IDLE at edge k.
  - The next gap begins at edge k+1, so the output turns on no earlier than edge k+2.
- enable falling at edge k gives both outputs 0 at edge k.
- enable rising always passes through a full dead_time+1 gap.

## Structure
- Shared package pwm_pkg:
  - state enum dt_state_t (6 values, binary encoded);
  - localparam DT_BITS_DEFAULT=4.
- Sub-module dt_counter (DT_BITS wide):
  - inputs: load, load_val, dec;
  - output: zero.
- The top holds the FSM, the output registers and the fault latch.
- Target size: about 150–250 lines total.

## Test plan
- Reset and idle: rst_n=0 for 2 cycles, then enable=0 with pwm_in toggling → pwm_hi=pwm_lo=fault_active=0 throughout.
- Dead time: dead_time=3, enable=1, pwm_in square wave with 20-cycle period → each edge gives exactly 4 both-low cycles; overlap never occurs (assertion).
- Zero and maximum gap: dead_time=0 gives a 1-cycle gap; dead_time=15 gives a 16-cycle gap.
- Short pulse: dead_time=5, a 3-cycle high pulse on pwm_in from LO_ON → pwm_hi never asserts; pwm_lo returns after the pulse, per the DT_RISE→LO_ON rule.
- Fault during HI_ON: fault for 1 cycle →
  - both outputs 0 and fault_active=1 at the same edge;
  - the state holds until clear_fault;
  - clear_fault together with fault=1 is ignored;
  - after a clean clear, pwm_hi returns only after a dead_time+1 gap.
- Mid-gap change: dead_time changes 8→2 during a DT_FALL gap → the current gap stays 9 cycles; the next gap is 3 cycles.
